// File: rtl/pattern_player_core_pkg.sv
// Shared configuration for the pattern player: default parameter values
// and the 2-bit FSM state encoding.
package pattern_player_core_pkg;

  localparam int DEF_SIGNAL_W = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_BUFFER_W = 10;
  localparam int DEF_LOOP_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pattern_player_core_buffer.sv
// Two-port sample RAM: one write port, one read port with a registered
// 1-cycle read; a same-address write and read return the old contents.
module pattern_player_core_buffer #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [1 << ADDR_W];

  // Non-blocking write alongside the read gives read-first behaviour.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/pattern_player_core.sv
// Pattern player: plays samples 0..len out of a software-written buffer,
// one-shot or looping, optionally gated by an external trigger.
module pattern_player_core
  import pattern_player_core_pkg::*;
#(
  parameter int SIGNAL_W = DEF_SIGNAL_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BUFFER_W = DEF_BUFFER_W,
  parameter int LOOP_W   = DEF_LOOP_W
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                rst_soft_i,
  input  logic                wr_en_i,
  input  logic [BUFFER_W-1:0] wr_addr_i,
  input  logic [SIGNAL_W-1:0] wr_data_i,
  input  logic [BUFFER_W-1:0] length_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                circular_i,
  input  logic                trigger_en_i,
  input  logic                trigger_i,
  input  logic                sample_en_i,
  output logic [SIGNAL_W-1:0] signal_o,
  output logic                signal_valid_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [LOOP_W-1:0]   loop_count_o
);

  if (SIGNAL_W < 1 || SIGNAL_W > DATA_W) begin : g_badWidth
    $error("SIGNAL_W must lie in 1..DATA_W");
  end

  state_e              state_q, state_d;
  logic [BUFFER_W-1:0] rdIdx_q, rdIdx_d;
  logic [BUFFER_W-1:0] len_q, len_d;
  logic                circ_q, circ_d;
  logic [LOOP_W-1:0]   loopCnt_q, loopCnt_d;
  logic                rdPend_q, rdPend_d;
  logic                valid_q, valid_d;
  logic [SIGNAL_W-1:0] signal_q, signal_d;
  logic                busy_q, done_q;
  logic                rdEn;
  logic [SIGNAL_W-1:0] ramData;

  pattern_player_core_buffer #(
    .WIDTH (SIGNAL_W),
    .ADDR_W(BUFFER_W)
  ) buffer (
    .clk_i    (clk_i),
    .wr_en_i  (wr_en_i & cke_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .rd_en_i  (rdEn & cke_i),
    .rd_addr_i(rdIdx_q),
    .rd_data_o(ramData)
  );

  always_comb begin
    state_d   = state_q;
    rdIdx_d   = rdIdx_q;
    len_d     = len_q;
    circ_d    = circ_q;
    loopCnt_d = loopCnt_q;
    rdEn      = 1'b0;

    if (stop_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            len_d     = length_i;
            circ_d    = circular_i;
            rdIdx_d   = '0;
            loopCnt_d = '0;
            state_d   = trigger_en_i ? ARMED : PLAY;
          end
        end
        ARMED: begin
          if (trigger_i) begin
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (sample_en_i) begin
            rdEn = 1'b1;
            if (rdIdx_q == len_q) begin
              if (circ_q) begin
                rdIdx_d = '0;
                if (loopCnt_q != {LOOP_W{1'b1}}) begin
                  loopCnt_d = loopCnt_q + LOOP_W'(1);
                end
              end else begin
                state_d = DONE;
              end
            end else begin
              rdIdx_d = rdIdx_q + BUFFER_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Two-stage read pipeline: RAM register, then output register. A stop
    // kills whatever is in flight; a DONE transition lets it drain.
    rdPend_d = rdEn;
    valid_d  = rdPend_q & ~stop_i;
    signal_d = valid_d ? ramData : signal_q;

    if (rst_soft_i) begin
      state_d   = IDLE;
      rdIdx_d   = '0;
      loopCnt_d = '0;
      rdEn      = 1'b0;
      rdPend_d  = 1'b0;
      valid_d   = 1'b0;
      signal_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      rdIdx_q   <= '0;
      len_q     <= '0;
      circ_q    <= 1'b0;
      loopCnt_q <= '0;
      rdPend_q  <= 1'b0;
      valid_q   <= 1'b0;
      signal_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      rdIdx_q   <= rdIdx_d;
      len_q     <= len_d;
      circ_q    <= circ_d;
      loopCnt_q <= loopCnt_d;
      rdPend_q  <= rdPend_d;
      valid_q   <= valid_d;
      signal_q  <= signal_d;
      busy_q    <= (state_d == ARMED) || (state_d == PLAY);
      done_q    <= (state_d == DONE);
    end
  end

  assign signal_o       = signal_q;
  assign signal_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign loop_count_o   = loopCnt_q;

endmodule

// File: tb/tb_pattern_player_core.sv
// Self-checking bench for pattern_player_core: a scoreboard of expected
// samples with their arrival cycle, table-driven playback runs, corner cases.
module tb_pattern_player_core;

  localparam int SW = 32;
  localparam int BW = 10;
  localparam int LW = 16;

  logic          clk_i = 1'b0;
  logic          arst_i, cke_i, rst_soft_i, wr_en_i;
  logic [BW-1:0] wr_addr_i, length_i;
  logic [SW-1:0] wr_data_i;
  logic          start_i, stop_i, circular_i, trigger_en_i, trigger_i, sample_en_i;
  logic [SW-1:0] signal_o;
  logic          signal_valid_o, busy_o, done_o;
  logic [LW-1:0] loop_count_o;

  pattern_player_core dut (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_soft_i(rst_soft_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .length_i(length_i), .start_i(start_i), .stop_i(stop_i),
    .circular_i(circular_i), .trigger_en_i(trigger_en_i), .trigger_i(trigger_i),
    .sample_en_i(sample_en_i), .signal_o(signal_o), .signal_valid_o(signal_valid_o),
    .busy_o(busy_o), .done_o(done_o), .loop_count_o(loop_count_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [SW-1:0] data;
    int            cyc;
  } exp_t;

  typedef struct {
    int len;
    bit circ;
    int nSen;
    int expLoop;
    bit expDone;
    bit expBusy;
  } vec_t;

  exp_t          expQ[$];
  exp_t          popE;
  logic [SW-1:0] memModel [8];
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at cyc %0d: got %0h required %0h", name, cyc, act, req);
    end
  endtask

  // Every valid pulse must match the next expected sample and arrive on its cycle.
  always @(negedge clk_i) begin
    if (signal_valid_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedPulse at cyc %0d: got %0h required no pulse", cyc, signal_o);
      end else begin
        popE = expQ.pop_front();
        checkOutput("sampleData", signal_o, popE.data);
        checkOutput("sampleCycle", cyc, popE.cyc);
      end
    end
  end

  task automatic pushExp(input logic [SW-1:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    expQ.push_back(e);
  endtask

  task automatic checkDrained(input string name);
    checkOutput(name, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic writeMem(input int a, input logic [SW-1:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = BW'(a);
    wr_data_i = d;
    @(negedge clk_i);
    wr_en_i = 1'b0;
    if (a < 8) memModel[a] = d;
  endtask

  task automatic stopPulse();
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input vec_t v);
    int n0, nReads;
    n0     = cyc;
    nReads = v.circ ? v.nSen : ((v.nSen < v.len + 1) ? v.nSen : v.len + 1);
    for (int k = 0; k < nReads; k++) pushExp(memModel[k % (v.len + 1)], n0 + 3 + k);
    start_i      = 1'b1;
    length_i     = BW'(v.len);
    circular_i   = v.circ;
    trigger_en_i = 1'b0;
    sample_en_i  = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
    length_i   = '1;
    circular_i = ~v.circ;
    repeat (v.nSen) @(negedge clk_i);
    sample_en_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checkDrained("rowDrained");
    checkOutput("rowLoopCount", loop_count_o, v.expLoop);
    checkOutput("rowDone", done_o, v.expDone);
    checkOutput("rowBusy", busy_o, v.expBusy);
    checkOutput("rowHoldLast", signal_o, memModel[(nReads - 1) % (v.len + 1)]);
    stopPulse();
    checkOutput("rowIdleAfterStop", {busy_o, done_o}, 2'b00);
  endtask

  task automatic abortTest(input bit useArst);
    int n0;
    n0 = cyc;
    start_i     = 1'b1;
    length_i    = '0;
    circular_i  = 1'b1;
    sample_en_i = 1'b1;
    pushExp(memModel[0], n0 + 3);
    pushExp(memModel[0], n0 + 4);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    if (useArst) arst_i = 1'b1;
    else         rst_soft_i = 1'b1;
    sample_en_i = 1'b0;
    @(negedge clk_i);
    checkOutput("abortSignal", signal_o, 0);
    checkOutput("abortValid", signal_valid_o, 0);
    checkOutput("abortBusyDone", {busy_o, done_o}, 2'b00);
    checkOutput("abortLoop", loop_count_o, 0);
    arst_i     = 1'b0;
    rst_soft_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkDrained("abortDrained");
    checkOutput("abortStaysIdle", busy_o, 0);
  endtask

  initial begin
    vec_t vecs[5];
    int   n0, m0;
    bit   busyOk;

    vecs[0] = '{len: 7, circ: 1'b0, nSen: 10, expLoop: 0, expDone: 1'b1, expBusy: 1'b0};
    vecs[1] = '{len: 3, circ: 1'b1, nSen: 10, expLoop: 2, expDone: 1'b0, expBusy: 1'b1};
    vecs[2] = '{len: 0, circ: 1'b0, nSen: 5,  expLoop: 0, expDone: 1'b1, expBusy: 1'b0};
    vecs[3] = '{len: 0, circ: 1'b1, nSen: 4,  expLoop: 4, expDone: 1'b0, expBusy: 1'b1};
    vecs[4] = '{len: 5, circ: 1'b1, nSen: 7,  expLoop: 1, expDone: 1'b0, expBusy: 1'b1};

    arst_i = 1'b1; cke_i = 1'b1; rst_soft_i = 1'b0; wr_en_i = 1'b0;
    wr_addr_i = '0; wr_data_i = '0; length_i = '0; start_i = 1'b0; stop_i = 1'b0;
    circular_i = 1'b0; trigger_en_i = 1'b0; trigger_i = 1'b0; sample_en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("resetSignal", signal_o, 0);
    checkOutput("resetValid", signal_valid_o, 0);
    checkOutput("resetBusyDone", {busy_o, done_o}, 2'b00);
    checkOutput("resetLoop", loop_count_o, 0);
    arst_i = 1'b0;
    @(negedge clk_i);

    for (int a = 0; a < 8; a++) writeMem(a, SW'(a + 'h10));

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Trigger: armed and silent for 20 cycles, first sample 3 cycles after trigger.
    start_i = 1'b1; trigger_en_i = 1'b1; length_i = 7; circular_i = 1'b0;
    sample_en_i = 1'b1; trigger_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    busyOk = 1'b1;
    repeat (20) begin
      @(negedge clk_i);
      if (busy_o !== 1'b1) busyOk = 1'b0;
    end
    checkOutput("armedBusy", busyOk, 1);
    m0 = cyc;
    trigger_i = 1'b1;
    for (int k = 0; k < 3; k++) pushExp(memModel[k], m0 + 3 + k);
    @(negedge clk_i);
    trigger_i = 1'b0;
    trigger_en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    sample_en_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checkDrained("trigDrained");
    checkOutput("trigBusy", busy_o, 1);
    stopPulse();

    // Rate strobe every 4th cycle, then stop together with a strobe.
    start_i = 1'b1; length_i = 7; circular_i = 1'b0; sample_en_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      sample_en_i = (c % 4 == 0);
      if (c % 4 == 0 && c < 12) pushExp(memModel[c / 4], cyc + 2);
      stop_i = (c == 12);
      @(negedge clk_i);
    end
    stop_i = 1'b0;
    sample_en_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checkDrained("rateDrained");
    checkOutput("rateStopIdle", {busy_o, done_o}, 2'b00);
    checkOutput("rateStopHold", signal_o, memModel[2]);

    // Start and stop in the same cycle: stop wins.
    start_i = 1'b1; stop_i = 1'b1; sample_en_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; stop_i = 1'b0;
    repeat (3) @(negedge clk_i);
    sample_en_i = 1'b0;
    checkOutput("startStopIdle", {busy_o, done_o}, 2'b00);

    abortTest(1'b0);
    abortTest(1'b1);

    // Write collision on index 2: old value this pass, new value next pass.
    n0 = cyc;
    start_i = 1'b1; length_i = 3; circular_i = 1'b1; sample_en_i = 1'b1;
    pushExp(SW'('h10), n0 + 3);
    pushExp(SW'('h11), n0 + 4);
    pushExp(SW'('h12), n0 + 5);
    pushExp(SW'('h13), n0 + 6);
    pushExp(SW'('h10), n0 + 7);
    pushExp(SW'('h11), n0 + 8);
    pushExp(SW'('hAB), n0 + 9);
    pushExp(SW'('h13), n0 + 10);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    writeMem(2, SW'('hAB));
    repeat (5) @(negedge clk_i);
    sample_en_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checkDrained("collisionDrained");
    checkOutput("collisionLoop", loop_count_o, 2);
    stopPulse();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
